// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM arbiter constants and line-fill state type
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_CNT_W  = $clog2(64);

  // One-hot so the handshake outputs decode from a single register bit
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    REQ  = 3'b010,
    DONE = 3'b100
  } fill_state_t;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - LINE_WORDS x 32 register file with indexed write and flat read-out
module line_buffer #(
  parameter int LINE_WORDS = 8,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [31:0]              wdata,
  output logic [LINE_WORDS*32-1:0] line
);

  logic [31:0] mem [LINE_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < LINE_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_comb begin
    line = '0;
    for (int i = 0; i < LINE_WORDS; i++) line[32*i +: 32] = mem[i];
  end

endmodule

// File: rtl/cache_line_fill.sv
// rtl/cache_line_fill.sv - single-line burst read initiator between cache miss logic and an arbiter read port
module cache_line_fill
  import sdram_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int CNT_W      = SDRAM_CNT_W,
  parameter int ADDR_W     = SDRAM_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_req,
  input  logic [ADDR_W-1:0]        miss_addr,
  output logic                     miss_ready,
  output logic                     fill_valid,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic [LINE_WORDS*32-1:0] fill_line,
  output logic                     fill_err,
  input  logic                     fill_ack,
  output logic                     readReq,
  output logic [ADDR_W-1:0]        req_addr,
  output logic [CNT_W-1:0]         transSize,
  input  logic                     readValid,
  input  logic [31:0]              readData,
  input  logic                     doneRead
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int WC_W  = OFF_W + 1;
  localparam logic [WC_W-1:0]   FULL     = WC_W'(LINE_WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS - 1);

  fill_state_t       state, state_next;
  logic [ADDR_W-1:0] line_addr;
  logic [WC_W-1:0]   wcnt, wcnt_final;
  logic              err;
  logic              accept, in_req, capture, overrun, finish;

  assign accept     = (state == IDLE) && miss_req;
  assign in_req     = (state == REQ);
  assign capture    = in_req && readValid && (wcnt < FULL);
  assign overrun    = in_req && readValid && (wcnt >= FULL);
  assign finish     = in_req && doneRead;
  // Count including a word that arrives alongside doneRead
  assign wcnt_final = wcnt + WC_W'(capture);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (miss_req) state_next = REQ;
      REQ:     if (doneRead) state_next = DONE;
      DONE:    if (fill_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    miss_ready = (state == IDLE);
    readReq    = (state == REQ);
    fill_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_addr <= '0;
      wcnt      <= '0;
      err       <= 1'b0;
    end else if (accept) begin
      line_addr <= miss_addr & ~OFF_MASK;
      wcnt      <= '0;
      err       <= 1'b0;
    end else if (in_req) begin
      wcnt <= wcnt_final;
      if (overrun || (finish && (wcnt_final != FULL))) err <= 1'b1;
    end
  end

  assign req_addr  = line_addr;
  assign fill_addr = line_addr;
  assign fill_err  = err;
  assign transSize = CNT_W'(LINE_WORDS);

  // Cleared on accept so a short burst leaves zeros in the unfilled words
  line_buffer #(
    .LINE_WORDS(LINE_WORDS)
  ) u_line_buffer (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .we   (capture),
    .idx  (wcnt[OFF_W-1:0]),
    .wdata(readData),
    .line (fill_line)
  );

endmodule

// File: tb/tb_cache_line_fill.sv
// tb/tb_cache_line_fill.sv - directed scoreboard bench for cache_line_fill with a behavioural arbiter port
module tb_cache_line_fill;

  localparam int LW = 8;
  localparam int AW = 25;
  localparam int CW = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           miss_req = 1'b0;
  logic [AW-1:0]  miss_addr = '0;
  logic           miss_ready;
  logic           fill_valid;
  logic [AW-1:0]  fill_addr;
  logic [LW*32-1:0] fill_line;
  logic           fill_err;
  logic           fill_ack = 1'b0;
  logic           readReq;
  logic [AW-1:0]  req_addr;
  logic [CW-1:0]  transSize;
  logic           readValid = 1'b0;
  logic [31:0]    readData = '0;
  logic           doneRead = 1'b0;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [LW*32-1:0] line;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   unstable;

  always #5 clk = ~clk;

  cache_line_fill #(.LINE_WORDS(LW), .CNT_W(CW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .miss_req  (miss_req),
    .miss_addr (miss_addr),
    .miss_ready(miss_ready),
    .fill_valid(fill_valid),
    .fill_addr (fill_addr),
    .fill_line (fill_line),
    .fill_err  (fill_err),
    .fill_ack  (fill_ack),
    .readReq   (readReq),
    .req_addr  (req_addr),
    .transSize (transSize),
    .readValid (readValid),
    .readData  (readData),
    .doneRead  (doneRead)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic samp_req(input logic [AW-1:0] ea);
    if (readReq !== 1'b1 || req_addr !== ea || transSize !== CW'(LW)) unstable = 1'b1;
  endtask

  // Pushes the expected fill, drives the miss and checks the request appears next cycle
  task automatic issue_miss(input logic [AW-1:0] a, input int n, input logic [31:0] base);
    exp_t e;
    e.addr = a & ~AW'(LW - 1);
    e.line = '0;
    for (int i = 0; i < LW; i++) if (i < n) e.line[32*i +: 32] = base + 32'(i);
    e.err = (n != LW);
    sb.push_back(e);
    chk("miss_ready_idle", 256'(miss_ready), 256'(1));
    miss_req  = 1'b1;
    miss_addr = a;
    @(negedge clk);
    miss_req = 1'b0;
    chk("readReq_t1", 256'(readReq), 256'(1));
    chk("miss_ready_t1", 256'(miss_ready), 256'(0));
    chk("req_addr", 256'(req_addr), 256'(e.addr));
    chk("transSize", 256'(transSize), 256'(LW));
  endtask

  // Behavioural arbiter port: grant delay, gapped words, doneRead; ends in cycle d+1
  task automatic serve(input int delay, input int n, input int gap_max, input bit same,
                       input logic [31:0] base, input logic [AW-1:0] ea);
    exp_t e;
    unstable = 1'b0;
    for (int k = 0; k < delay; k++) begin
      samp_req(ea);
      @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      samp_req(ea);
      readValid = 1'b1;
      readData  = base + 32'(i);
      if (same && i == n - 1) doneRead = 1'b1;
      @(negedge clk);
      readValid = 1'b0;
      doneRead  = 1'b0;
      if (!(same && i == n - 1)) begin
        for (int g = $urandom_range(0, gap_max); g > 0; g--) begin
          samp_req(ea);
          @(negedge clk);
        end
      end
    end
    if (!same) begin
      samp_req(ea);
      doneRead = 1'b1;
      @(negedge clk);
      doneRead = 1'b0;
    end
    chk("req_stable", 256'(unstable), 256'(0));
    chk("readReq_after_done", 256'(readReq), 256'(0));
    chk("fill_valid_after_done", 256'(fill_valid), 256'(1));
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 256'(0), 256'(1));
    end else begin
      e = sb.pop_front();
      chk("fill_addr", 256'(fill_addr), 256'(e.addr));
      chk("fill_line", fill_line, e.line);
      chk("fill_err", 256'(fill_err), 256'(e.err));
    end
  endtask

  task automatic ack();
    fill_ack = 1'b1;
    @(negedge clk);
    fill_ack = 1'b0;
    chk("fill_valid_after_ack", 256'(fill_valid), 256'(0));
    chk("miss_ready_after_ack", 256'(miss_ready), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t drop;
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_miss_ready", 256'(miss_ready), 256'(1));
    chk("rst_readReq", 256'(readReq), 256'(0));
    chk("rst_fill_valid", 256'(fill_valid), 256'(0));
    chk("rst_fill_err", 256'(fill_err), 256'(0));
    chk("rst_req_addr", 256'(req_addr), 256'(0));
    chk("rst_fill_line", fill_line, 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // 1: basic fill
    issue_miss(25'h00013, 8, 32'hA0);
    serve(0, 8, 0, 1'b0, 32'hA0, 25'h00010);
    ack();

    // 2: delayed grant, gapped words
    issue_miss(25'h00013, 8, 32'hA0);
    serve(20, 8, 3, 1'b0, 32'hA0, 25'h00010);
    ack();

    // 3: overrun, ninth word dropped
    issue_miss(25'h1234F, 9, 32'hB0);
    serve(2, 9, 1, 1'b0, 32'hB0, 25'h12348);
    ack();

    // 4: short burst, then last word together with doneRead
    issue_miss(25'h00100, 5, 32'hC0);
    serve(1, 5, 2, 1'b0, 32'hC0, 25'h00100);
    ack();
    issue_miss(25'h00207, 8, 32'hD0);
    serve(0, 8, 1, 1'b1, 32'hD0, 25'h00200);
    chk("same_cycle_err_persist", 256'(fill_err), 256'(0));
    ack();

    // 5: fill_ack held high and a second miss queued
    issue_miss(25'h00031, 8, 32'h10);
    fill_ack = 1'b1;
    serve(0, 8, 0, 1'b0, 32'h10, 25'h00030);
    miss_req  = 1'b1;
    miss_addr = 25'h1FFFFFF;
    begin
      exp_t e2;
      e2.addr = 25'h1FFFFF8;
      e2.line = '0;
      for (int i = 0; i < LW; i++) e2.line[32*i +: 32] = 32'h20 + 32'(i);
      e2.err = 1'b0;
      sb.push_back(e2);
    end
    @(negedge clk);
    chk("held_ack_fill_valid_a1", 256'(fill_valid), 256'(0));
    chk("held_ack_miss_ready_a1", 256'(miss_ready), 256'(1));
    chk("held_ack_readReq_a1", 256'(readReq), 256'(0));
    @(negedge clk);
    miss_req = 1'b0;
    fill_ack = 1'b0;
    chk("b2b_readReq_a2", 256'(readReq), 256'(1));
    chk("b2b_req_addr", 256'(req_addr), 256'(25'h1FFFFF8));
    serve(3, 8, 2, 1'b0, 32'h20, 25'h1FFFFF8);
    ack();

    // 6: reset after three words aborts the fill
    issue_miss(25'h00044, 8, 32'hE0);
    for (int i = 0; i < 3; i++) begin
      readValid = 1'b1;
      readData  = 32'hE0 + 32'(i);
      @(negedge clk);
      readValid = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_readReq", 256'(readReq), 256'(0));
    chk("mid_rst_miss_ready", 256'(miss_ready), 256'(1));
    chk("mid_rst_fill_valid", 256'(fill_valid), 256'(0));
    chk("mid_rst_fill_err", 256'(fill_err), 256'(0));
    chk("mid_rst_req_addr", 256'(req_addr), 256'(0));
    chk("mid_rst_fill_addr", 256'(fill_addr), 256'(0));
    chk("mid_rst_fill_line", fill_line, 256'(0));
    drop = sb.pop_front();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue_miss(25'h00055, 8, 32'hF0);
    serve(0, 8, 1, 1'b0, 32'hF0, 25'h00050);
    ack();

    chk("scoreboard_drained", 256'(sb.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_line_fill.md
# cache_line_fill

Cache-side read initiator for the SDRAM memory request arbiter. One instance sits between a cache's miss logic and one read port of the arbiter. It accepts a single line-miss request, holds a burst read request (`readReq`/`addr`/`transSize`) until the arbiter signals completion, and assembles the returned words into a line buffer. It then presents the full line to the cache with a valid/ack handshake.

## Interface

**Parameters**
- `LINE_WORDS`, default 8: words per line. Power of two, 2..32.
- `CNT_W`, default 6: width of `transSize`. Must equal the arbiter's $clog2(maxTrans).
- `ADDR_W`, default 25: SDRAM word address width.

**Ports** (clock and reset first)
- `clk`  in  1  system clock.
- `rst`  in  1  reset: asynchronous, active-high. Clock is `clk`.
- `miss_req`  in  1  cache requests a line fill.
- `miss_addr`  in  ADDR_W  word address of the miss, any alignment.
- `miss_ready`  out  1  block is idle and can accept a miss.
- `fill_valid`  out  1  `fill_line` holds a completed line.
- `fill_addr`  out  ADDR_W  line-aligned address of `fill_line`.
- `fill_line`  out  LINE_WORDS*32  line data; word i is at bits [32i+31:32i].
- `fill_err`  out  1  the completed fill had a word-count mismatch.
- `fill_ack`  in  1  cache has consumed the line.
- `readReq`  out  1  to arbiter: read request.
- `req_addr`  out  ADDR_W  to arbiter: line-aligned burst address.
- `transSize`  out  CNT_W  to arbiter: burst length, constant LINE_WORDS.
- `readValid`  in  1  from arbiter: a data word is present this cycle.
- `readData`  in  32  from arbiter: the data word.
- `doneRead`  in  1  from arbiter: one-cycle pulse marking the end of the burst.

## Operation

**States**
- `IDLE`: `miss_ready`=1. On `miss_req`, latch `line_addr = miss_addr` with the low $clog2(LINE_WORDS) bits cleared, clear `wcnt` and `err`, and go to `REQ`.
- `REQ`: `readReq`=1, with `req_addr`=`line_addr` held stable.
  - On `readValid` with `wcnt < LINE_WORDS`: write `readData` to `line[wcnt]` and increment `wcnt`.
  - On `readValid` with `wcnt == LINE_WORDS`: drop the word and set `err`.
  - On `doneRead`: set `err` if the final word count is not LINE_WORDS, then go to `DONE`.
  - If `readValid` and `doneRead` occur in the same cycle, accept the word first, then check the count including that word.
- `DONE`: `fill_valid`=1, and `fill_line`, `fill_addr` and `fill_err` are held stable. On `fill_ack`, go to `IDLE`.

**Fixed and ignored signals**
- `transSize` is the constant LINE_WORDS, zero-extended to CNT_W.
- `readValid` and `doneRead` are ignored outside `REQ`.
- `fill_ack` is ignored outside `DONE`.

**Width rules**
- `wcnt` is $clog2(LINE_WORDS)+1 bits wide so it never wraps.

**Reset values** (an asynchronous reset mid-burst aborts the fill)
- State `IDLE`, `miss_ready`=1.
- `readReq`=0, `fill_valid`=0, `fill_err`=0.
- `req_addr`=0, `fill_addr`=0, `line`=0, `wcnt`=0.
- The arbiter is reset from the same `rst`, so no cleanup handshake is needed.

## Timing

- **Miss accept:** `miss_req && miss_ready` is sampled at edge t. `readReq` goes high in cycle t+1, and `miss_ready` goes low in cycle t+1.
- **Request hold:** `readReq`, `req_addr` and `transSize` come straight from registers and stay stable from t+1 through the cycle in which `doneRead` is seen.
- **Request release:** `doneRead` is seen in cycle d. `readReq` is low from cycle d+1, so the idle arbiter cannot re-grant the same port. `fill_valid` is high from cycle d+1.
- **Word capture:** each word is written at the edge where `readValid` is sampled high. There is no backpressure toward the arbiter.
- **Line release:** `fill_ack` is sampled with `fill_valid` high at edge a. `fill_valid` is low and `miss_ready` is high in cycle a+1.
- **Back-to-back misses:** the earliest next `readReq` is cycle a+2.
- **Held `fill_ack`:** if `fill_ack` is held high, the line is accepted on the first `DONE` cycle.
- **Clearing:** `fill_err` clears on the next miss accept.

## Structure

- Shared package `sdram_pkg`:
  - `SDRAM_ADDR_W`=25 and `SDRAM_CNT_W`=$clog2(64), reused by the arbiter.
  - `fill_state_t` enum: `IDLE`, `REQ`, `DONE`.
- Sub-module `line_buffer`: LINE_WORDS×32 register file with a write-enable/index port and a flat read-out. It has no reset behaviour beyond clearing to 0.
- The control FSM, address latch and `wcnt` counter live in the top level.
- The testbench uses a behavioural arbiter-port model with a programmable grant delay, inter-word gaps and word count.

## Test plan

1. **Basic fill.** `miss_addr`=0x00013, LINE_WORDS=8, model returns 0xA0..0xA7 and then `doneRead`.
   - Required: `req_addr`=0x00010, `transSize`=8, `fill_line` words 0..7 = 0xA0..0xA7, `fill_err`=0, `readReq` low the cycle after `doneRead`.
2. **Gapped words and delayed grant.** Grant after 20 cycles, 0–3 idle cycles between words.
   - Required: same line as scenario 1, and `readReq`/`req_addr` stable throughout.
3. **Overrun.** Model sends 9 words, then `doneRead`.
   - Required: words 0..7 as sent, 9th word dropped, `fill_err`=1.
4. **Short burst.** Model sends 5 words, then `doneRead`.
   - Required: words 0..4 written, words 5..7 = 0, `fill_err`=1.
   - Same cycle: last word arrives together with `doneRead` → word is captured, and the fill completes with `fill_err`=0 when it is the 8th word.
5. **Ack held and back-to-back.** `fill_ack` held high, and a second miss 0x1FFFFFF is queued.
   - Required: `fill_valid` high for exactly 1 cycle, second `readReq` at a+2 with `req_addr`=0x1FFFFF8.
6. **Mid-burst reset.** `rst` asserted after 3 words.
   - Required: all outputs at their reset values immediately, then a fresh fill completes correctly.
